aes_inv_key_sched: RTL

Iterative AES-128 inverse key scheduler for the decryption datapath. It accepts a cipher key and expands it forward one round per cycle to reach the last round key. It then streams round keys in decryption order (round 10 down to round 0) over a valid/ready interface, recomputing each previous round key on the fly rather than storing the full schedule. It sits between key load and the inverse-cipher round engine.

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_inv_key_sched_if.sv | 23 ++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_inv_key_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse key scheduler: S-box table, Rcon,
// word helpers, round/key-length constants and the scheduler state encoding.
package aes_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2
  } ks_state_e;

  // Byte x of the forward S-box sits at bits [8*(255-x) +: 8].
  localparam logic [2047:0] SBOX_TBL = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Key-load and round-key stream bundle of the inverse key scheduler.
interface aes_inv_key_sched_if;

  logic [127:0] key_in;
  logic         start;
  logic         busy;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;

  modport master (
    output key_in, start, rk_ready,
    input  busy, rk_out, rk_idx, rk_valid, done
  );

  modport slave (
    input  key_in, start, rk_ready,
    output busy, rk_out, rk_idx, rk_valid, done
  );

endinterface

// File: rtl/aes_sbox.sv
// Single combinational AES forward S-box byte lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = sbox(din);

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key scheduler: expands forward to round 10, then
// streams round keys 10..0. Optional last-key cache: AES_INV_KS_CACHE_EN.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_key_sched_if.slave   ks
);

  if (NK != AES_NK) begin : g_bad_nk
    $error("aes_inv_key_sched: only NK=4 is supported");
  end
  if (NR != AES_NR) begin : g_bad_nr
    $error("aes_inv_key_sched: only NR=10 is supported");
  end

  localparam logic [3:0] LAST_FWD = 4'(NR - 1);
  localparam logic [3:0] IDX_TOP  = 4'(NR);

  ks_state_e    state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] key_q, key_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sb_in, sb_rot, sb_out, rcon_w;
  logic [3:0]   rcon_sel;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  p0, p1, p2, p3;
  logic [127:0] fwd_key, rev_key;
  logic         start_acc, accept;
  logic         cache_hit;
  logic [127:0] cache_rk;

  assign {w0, w1, w2, w3} = key_q;

  // One shared SubWord: w3 drives it going forward, w3^w2 (= previous w3) going back.
  assign sb_in  = (state_q == ST_REV) ? (w3 ^ w2) : w3;
  assign sb_rot = rot_word(sb_in);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (sb_rot[8*i +: 8]),
      .dout (sb_out[8*i +: 8])
    );
  end

  assign rcon_sel = (state_q == ST_REV) ? idx_q : (cnt_q + 4'd1);
  assign rcon_w   = {rcon(rcon_sel), 24'h000000};

  assign f0      = w0 ^ sb_out ^ rcon_w;
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};

  assign p3      = w3 ^ w2;
  assign p2      = w2 ^ w1;
  assign p1      = w1 ^ w0;
  assign p0      = w0 ^ sb_out ^ rcon_w;
  assign rev_key = {p0, p1, p2, p3};

  // The done cycle already sits in IDLE, so a start seen alongside done is dropped.
  assign start_acc = (state_q == ST_IDLE) && ks.start && !done_q;
  assign accept    = valid_q && ks.rk_ready;

`ifdef AES_INV_KS_CACHE_EN
  logic         cache_vld_q, cache_vld_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk_q,  cache_rk_d;

  assign cache_hit = cache_vld_q && (ks.key_in == cache_key_q);
  assign cache_rk  = cache_rk_q;

  always_comb begin
    cache_vld_d = cache_vld_q;
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
    if (start_acc && !cache_hit) begin
      cache_vld_d = 1'b0;
      cache_key_d = ks.key_in;
    end
    if ((state_q == ST_FWD) && (cnt_q == LAST_FWD)) begin
      cache_vld_d = 1'b1;
      cache_rk_d  = fwd_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      cache_rk_q  <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_rk  = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    key_d   = key_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          busy_d = 1'b1;
          cnt_d  = 4'd0;
          if (cache_hit) begin
            key_d   = cache_rk;
            idx_d   = IDX_TOP;
            valid_d = 1'b1;
            state_d = ST_REV;
          end else begin
            key_d   = ks.key_in;
            state_d = ST_FWD;
          end
        end
      end
      ST_FWD: begin
        key_d = fwd_key;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_FWD) begin
          idx_d   = IDX_TOP;
          valid_d = 1'b1;
          state_d = ST_REV;
        end
      end
      ST_REV: begin
        if (accept) begin
          if (idx_q != 4'd0) begin
            key_d = rev_key;
            idx_d = idx_q - 4'd1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      key_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ks.rk_out   = key_q;
  assign ks.rk_idx   = idx_q;
  assign ks.rk_valid = valid_q;
  assign ks.busy     = busy_q;
  assign ks.done     = done_q;

endmodule
